// File: rtl/display_update_scheduler_pkg.sv
// rtl/display_update_scheduler_pkg.sv - shared types and constants for the display update scheduler
//
// Contents:
//   SEG_WIDTH   default segment word width (7 segments x 6 digits)
//   SEG_ALL_ON  lamp-test word, every segment lit
//   SEG_ALL_OFF blank word, every segment dark
//   state_t     transfer sequencer states
package display_update_scheduler_pkg;

    localparam int SEG_WIDTH = 7 * 6;

    localparam logic [SEG_WIDTH-1:0] SEG_ALL_ON  = '1;
    localparam logic [SEG_WIDTH-1:0] SEG_ALL_OFF = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_BUSY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/display_update_scheduler_sat_counter.sv
// rtl/display_update_scheduler_sat_counter.sv - saturating up-counter
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset, clears the count
//   inc_i    add one this cycle (ignored once the count is all ones)
//   count_o  current count, sticks at its maximum value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (inc_i && (count_o != {W{1'b1}})) begin
            count_o <= count_o + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/display_update_scheduler.sv
// rtl/display_update_scheduler.sv - merges display update requests into gapped shift-register transfers
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   tick_req_i     pulse: seconds digits advanced
//   load_req_i     pulse: digits reloaded from decoded time
//   test_i         level: lamp test (all segments on)
//   blank_i        level: blank display (all segments off), overrides test_i
//   time_seg_i     live segment word from the digit encoder
//   sr_busy_i      shift engine busy, rises the cycle after a start
//   sr_start_o     single-cycle transfer start
//   sr_data_o      segment word frozen at the last start
//   overrun_cnt_o  saturating count of cycles where a request merged into a pending one
//   arm_err_o      sticky: the engine never went busy after a start
module display_update_scheduler
    import display_update_scheduler_pkg::*;
#(
    parameter int WIDTH       = SEG_WIDTH,
    parameter int GAP_CYCLES  = 4,
    parameter int ARM_TIMEOUT = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_req_i,
    input  logic             load_req_i,
    input  logic             test_i,
    input  logic             blank_i,
    input  logic [WIDTH-1:0] time_seg_i,
    input  logic             sr_busy_i,
    output logic             sr_start_o,
    output logic [WIDTH-1:0] sr_data_o,
    output logic [7:0]       overrun_cnt_o,
    output logic             arm_err_o
);

    state_t           state_q, state_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             pend_q;
    logic             test_q, blank_q;
    logic             start_q;
    logic             arm_err_q;
    logic [WIDTH-1:0] data_q;

    logic             mode_edge;
    logic             req;
    logic             start_now;
    logic             arm_fail;
    logic [WIDTH-1:0] sel_data;

    // Any change of either mode level needs the display redrawn once.
    assign mode_edge = (test_i ^ test_q) | (blank_i ^ blank_q);
    assign req       = tick_req_i | load_req_i | mode_edge;
    assign start_now = (state_q == ST_IDLE) && pend_q;

    assign sel_data = blank_i ? WIDTH'(SEG_ALL_OFF) :
                      test_i  ? WIDTH'(SEG_ALL_ON)  :
                                time_seg_i;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        gap_cnt_d = gap_cnt_q;
        arm_fail  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                end
            end
            ST_ARM: begin
                if (sr_busy_i) begin
                    state_d = ST_BUSY;
                end else if (arm_cnt_q == 3'(ARM_TIMEOUT - 1)) begin
                    // Engine never acknowledged; flag it and still honour the gap.
                    arm_fail  = 1'b1;
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 3'd1;
                end
            end
            ST_BUSY: begin
                if (!sr_busy_i) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            arm_cnt_q <= '0;
            gap_cnt_q <= '0;
            pend_q    <= 1'b0;
            test_q    <= 1'b0;
            blank_q   <= 1'b0;
            start_q   <= 1'b0;
            arm_err_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            test_q    <= test_i;
            blank_q   <= blank_i;
            start_q   <= start_now;
            // A request arriving with the start is kept for the next transfer.
            pend_q    <= req | (pend_q & ~start_now);
            if (start_now) begin
                data_q <= sel_data;
            end
            if (arm_fail) begin
                arm_err_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (8)
    ) u_overrun_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (req & pend_q),
        .count_o (overrun_cnt_o)
    );

    assign sr_start_o = start_q;
    assign sr_data_o  = data_q;
    assign arm_err_o  = arm_err_q;

endmodule

// File: tb/tb_display_update_scheduler.sv
// tb/tb_display_update_scheduler.sv - self-checking bench for display_update_scheduler
module tb_display_update_scheduler;

    localparam int W    = 42;
    localparam int GAP  = 4;
    localparam int ARM  = 3;
    localparam logic [W-1:0] TS_A = 42'h2AB_CDEF_0123;
    localparam logic [W-1:0] TS_B = 42'h12_3456_789A;
    localparam logic [W-1:0] TS_C = 42'h3FF_0000_FFFF;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         tick = 1'b0;
    logic         load = 1'b0;
    logic         test = 1'b0;
    logic         blank = 1'b0;
    logic [W-1:0] time_seg = '0;
    logic         sr_busy = 1'b0;
    logic         sr_start_o;
    logic [W-1:0] sr_data_o;
    logic [7:0]   overrun_cnt_o;
    logic         arm_err_o;

    int n_cmp = 0;
    int n_fail = 0;

    // bench-side engine behaviour
    bit eng_resp = 1'b1;
    int busy_len = 44;

    always #5 clk_i = ~clk_i;

    display_update_scheduler #(
        .WIDTH       (W),
        .GAP_CYCLES  (GAP),
        .ARM_TIMEOUT (ARM)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tick_req_i    (tick),
        .load_req_i    (load),
        .test_i        (test),
        .blank_i       (blank),
        .time_seg_i    (time_seg),
        .sr_busy_i     (sr_busy),
        .sr_start_o    (sr_start_o),
        .sr_data_o     (sr_data_o),
        .overrun_cnt_o (overrun_cnt_o),
        .arm_err_o     (arm_err_o)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_start(input int budget, input string nm);
        for (int i = 0; i < budget && !sr_start_o; i++) step(1);
        check(nm, {63'd0, sr_start_o}, 64'd1);
    endtask

    // Engine: goes busy the cycle after it sees a start, for busy_len cycles.
    initial begin
        int  bleft;
        bit  start_seen;
        bleft = 0;
        start_seen = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (bleft > 0) begin
                bleft--;
                if (bleft == 0) sr_busy = 1'b0;
            end else if (start_seen && eng_resp) begin
                sr_busy = 1'b1;
                bleft = busy_len;
            end
            start_seen = sr_start_o;
        end
    end

    // Timeline model: edge index m_cyc; a start may register no earlier than
    // m_earliest, derived from how long the engine stays busy plus the gap.
    int           m_cyc = 0;
    int           m_earliest = 0;
    int           m_arm_at = 0;
    int           m_cnt = 0;
    bit           m_pend = 0, m_start = 0, m_arm = 0, m_armwait = 0;
    bit           m_test_prev = 0, m_blank_prev = 0;
    logic [W-1:0] m_data = '0;

    initial begin
        forever begin
            bit req, go;
            @(posedge clk_i);
            m_cyc++;
            if (!rst_ni) begin
                m_pend = 0; m_start = 0; m_arm = 0; m_armwait = 0;
                m_test_prev = 0; m_blank_prev = 0; m_data = '0;
                m_cnt = 0; m_earliest = 0;
            end else begin
                req = tick || load || (test != m_test_prev) || (blank != m_blank_prev);
                go  = m_pend && (m_cyc >= m_earliest);
                if (req && m_pend && m_cnt < 255) m_cnt++;
                m_start = go;
                if (go) begin
                    m_data = blank ? '0 : (test ? '1 : time_seg);
                    m_pend = req;
                    if (eng_resp) begin
                        m_earliest = m_cyc + 2 + busy_len + GAP + 1;
                    end else begin
                        m_earliest = m_cyc + ARM + GAP + 1;
                        m_armwait = 1;
                        m_arm_at = m_cyc + ARM;
                    end
                end else if (req) begin
                    m_pend = 1;
                end
                if (m_armwait && m_cyc == m_arm_at) begin
                    m_arm = 1;
                    m_armwait = 0;
                end
                m_test_prev = test;
                m_blank_prev = blank;
            end
        end
    end

    int           n_starts = 0;
    logic [W-1:0] last_data = '0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("sr_start_o", {63'd0, sr_start_o}, {63'd0, m_start});
            check("sr_data_o", {22'd0, sr_data_o}, {22'd0, m_data});
            check("overrun_cnt_o", {56'd0, overrun_cnt_o}, 64'(m_cnt));
            check("arm_err_o", {63'd0, arm_err_o}, {63'd0, m_arm});
            if (sr_start_o) begin
                n_starts++;
                last_data = sr_data_o;
            end
        end
    end

    initial begin
        int k, n0;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_start", {63'd0, sr_start_o}, 64'd0);
        check("reset_data", {22'd0, sr_data_o}, 64'd0);
        check("reset_overrun", {56'd0, overrun_cnt_o}, 64'd0);
        check("reset_arm_err", {63'd0, arm_err_o}, 64'd0);
        rst_ni = 1'b1;
        step(2);

        // single tick, 44-cycle engine
        time_seg = TS_A;
        tick = 1; step(1); tick = 0;
        check("s1_no_start_yet", {63'd0, sr_start_o}, 64'd0);
        step(1);
        check("s1_start", {63'd0, sr_start_o}, 64'd1);
        check("s1_data", {22'd0, sr_data_o}, {22'd0, TS_A});
        k = m_cyc;
        time_seg = TS_B;
        step(10);
        check("s1_data_held", {22'd0, sr_data_o}, {22'd0, TS_A});
        tick = 1; step(1); tick = 0;
        wait_start(80, "s1_second_start");
        check("s1_start_spacing", 64'(m_cyc - k), 64'd51);
        check("s1_second_data", {22'd0, sr_data_o}, {22'd0, TS_B});
        step(70);

        // tick, load two cycles later, two ticks during busy
        busy_len = 10;
        n0 = n_starts;
        tick = 1; step(1); tick = 0; step(1);
        load = 1; step(1); load = 0; step(2);
        tick = 1; step(1); tick = 0; step(1);
        tick = 1; step(1); tick = 0;
        step(40);
        check("s2_start_count", 64'(n_starts - n0), 64'd2);
        check("s2_overrun", {56'd0, overrun_cnt_o}, 64'd2);

        // lamp test, blank, then both dropped
        n0 = n_starts;
        tick = 1; step(1); tick = 0; step(4);
        test = 1;
        step(40);
        check("s3_test_count", 64'(n_starts - n0), 64'd2);
        check("s3_test_data", {22'd0, last_data}, {22'd0, {W{1'b1}}});
        blank = 1;
        step(40);
        check("s3_blank_count", 64'(n_starts - n0), 64'd3);
        check("s3_blank_data", {22'd0, last_data}, 64'd0);
        time_seg = TS_C; test = 0; blank = 0;
        step(40);
        check("s3_live_count", 64'(n_starts - n0), 64'd4);
        check("s3_live_data", {22'd0, last_data}, {22'd0, TS_C});

        // engine never goes busy
        eng_resp = 0;
        tick = 1; step(1); tick = 0; step(1);
        check("s4_start", {63'd0, sr_start_o}, 64'd1);
        k = m_cyc;
        tick = 1; step(1); tick = 0;
        step(1);
        check("s4_arm_err_early", {63'd0, arm_err_o}, 64'd0);
        step(1);
        check("s4_arm_err_set", {63'd0, arm_err_o}, 64'd1);
        wait_start(20, "s4_pending_start");
        check("s4_start_spacing", 64'(m_cyc - k), 64'd8);
        step(20);
        eng_resp = 1;
        busy_len = 30;

        // reset mid-busy with a pending request
        tick = 1; step(1); tick = 0; step(5);
        tick = 1; step(1); tick = 0; step(3);
        rst_ni = 0;
        #1;
        check("s5_rst_start", {63'd0, sr_start_o}, 64'd0);
        check("s5_rst_data", {22'd0, sr_data_o}, 64'd0);
        check("s5_rst_overrun", {56'd0, overrun_cnt_o}, 64'd0);
        check("s5_rst_arm_err", {63'd0, arm_err_o}, 64'd0);
        step(2);
        rst_ni = 1;
        n0 = n_starts;
        step(60);
        check("s5_no_start", 64'(n_starts - n0), 64'd0);
        tick = 1; step(300); tick = 0;
        check("s5_saturate", {56'd0, overrun_cnt_o}, 64'd255);
        step(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
